// File: rtl/histo_readout_pkg.sv
// Shared types and constants for the histogram readout sequencer.
// Optional checksum byte: define HISTO_READOUT_CHECKSUM_EN.
package histo_readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SELECT,
        ST_CAPTURE,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } state_t;

    localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
    localparam int unsigned IDX_W          = 5;
    localparam int unsigned BYTE_W         = 8;

endpackage

// File: rtl/histo_byte_tx.sv
// Output byte holder with valid/ready handshake; data is frozen while a byte waits.
module histo_byte_tx
    import histo_readout_pkg::*;
(
    input  logic              clk_adc,
    input  logic              rst,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_data,
    input  logic              tx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              accepted_c
);

    // A byte leaves on the cycle the sink takes it.
    assign accepted_c = tx_valid && tx_ready;

    // Present a new byte only when the slot is empty or being emptied this cycle.
    always_ff @(posedge clk_adc) begin
        if (rst) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (load && (!tx_valid || accepted_c)) begin
            tx_data  <= load_data;
            tx_valid <= 1'b1;
        end else if (accepted_c) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/histo_readout.sv
// Histogram readout sequencer: walks all channels, snapshots each channel's
// words and streams header + data bytes to the transmit FIFO.
// Optional checksum byte: define HISTO_READOUT_CHECKSUM_EN.
module histo_readout
    import histo_readout_pkg::*;
#(
    parameter int unsigned NCHAN  = 16,
    parameter int unsigned NHIST  = 8,
    parameter int unsigned SETTLE = 4,
    parameter logic [7:0]  HEADER = HEADER_DEFAULT
) (
    input  logic                clk_adc,
    input  logic                rst,
    input  logic                start,
    input  logic                clear_after_read,
    input  logic [NHIST*32-1:0] histosin,
    output logic [7:0]          histostosend,
    output logic                resethist,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done
);

    localparam int unsigned SET_W = $clog2(SETTLE + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NHIST * 4 - 1);
    localparam logic [7:0]       CH_LAST  = 8'(NCHAN - 1);

    state_t                state;
    logic [SET_W-1:0]      settle;
    logic [IDX_W-1:0]      idx;
    logic [NHIST*32-1:0]   shadow;
    logic                  clr_lat;
    logic                  last_ch;
    logic                  load_c;
    logic [BYTE_W-1:0]     load_data_c;
    logic                  accepted_c;

    // Byte idx of a word set: word idx[4:2], most significant byte first.
    function automatic logic [BYTE_W-1:0] pick_byte(input logic [NHIST*32-1:0] w,
                                                    input logic [IDX_W-1:0]    i);
        logic [IDX_W-3:0] w_i;
        logic [1:0]       b_i;
        logic [31:0]      word;
        w_i  = i[IDX_W-1:2];
        b_i  = 2'd3 - i[1:0];
        word = w[{w_i, 5'b00000} +: 32];
        return word[{b_i, 3'b000} +: 8];
    endfunction

    assign last_ch = (histostosend == CH_LAST);

`ifdef HISTO_READOUT_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_acc;

    // Running XOR of every byte accepted since start.
    always_ff @(posedge clk_adc) begin
        if (rst) begin
            csum_acc <= '0;
        end else if (state == ST_IDLE && start) begin
            csum_acc <= '0;
        end else if (accepted_c) begin
            csum_acc <= csum_acc ^ tx_data;
        end
    end
`endif

    // Choose the next byte to hand to the transmitter.
    always_comb begin
        load_c      = 1'b0;
        load_data_c = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_c      = 1'b1;
                    load_data_c = HEADER;
                end
            end
            ST_CAPTURE: begin
                load_c      = 1'b1;
                load_data_c = pick_byte(histosin, IDX_W'(0));
            end
            ST_SEND: begin
                if (accepted_c) begin
                    if (idx != IDX_LAST) begin
                        load_c      = 1'b1;
                        load_data_c = pick_byte(shadow, idx + IDX_W'(1));
                    end
`ifdef HISTO_READOUT_CHECKSUM_EN
                    else if (last_ch) begin
                        load_c      = 1'b1;
                        load_data_c = csum_acc ^ tx_data;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    // Frame sequencer: header, per-channel select/settle/capture/send, optional checksum, done.
    always_ff @(posedge clk_adc) begin
        if (rst) begin
            state        <= ST_IDLE;
            settle       <= '0;
            idx          <= '0;
            shadow       <= '0;
            clr_lat      <= 1'b0;
            histostosend <= '0;
            resethist    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done      <= 1'b0;
            resethist <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_HEADER;
                        busy    <= 1'b1;
                        clr_lat <= clear_after_read;
                    end
                end
                ST_HEADER: begin
                    if (accepted_c) begin
                        state        <= ST_SELECT;
                        histostosend <= '0;
                        settle       <= '0;
                    end
                end
                ST_SELECT: begin
                    if (settle == SET_W'(SETTLE - 1)) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle <= settle + SET_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    shadow <= histosin;
                    idx    <= '0;
                    state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (accepted_c) begin
                        if (idx != IDX_LAST) begin
                            idx <= idx + IDX_W'(1);
                        end else if (!last_ch) begin
                            state        <= ST_SELECT;
                            histostosend <= histostosend + 8'd1;
                            settle       <= '0;
                        end else begin
`ifdef HISTO_READOUT_CHECKSUM_EN
                            state     <= ST_CSUM;
`else
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            resethist <= clr_lat;
`endif
                        end
                    end
                end
                ST_CSUM: begin
                    if (accepted_c) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        resethist <= clr_lat;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output byte register and handshake.
    histo_byte_tx u_tx (
        .clk_adc    (clk_adc),
        .rst        (rst),
        .load       (load_c),
        .load_data  (load_data_c),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .accepted_c (accepted_c)
    );

endmodule

// File: tb/tb_histo_readout.sv
// Bench for histo_readout: scoreboarded byte stream, handshake stability,
// frame timing, clear pulse, restart and mid-frame reset.
module tb_histo_readout;

    localparam int unsigned NCHAN = 16;
    localparam int unsigned NHIST = 8;
    localparam logic [7:0]  HDR   = 8'hA5;
`ifdef HISTO_READOUT_CHECKSUM_EN
    localparam int FRAME_LEN = 514;
    localparam int FRAME_CYC = 595;
`else
    localparam int FRAME_LEN = 513;
    localparam int FRAME_CYC = 594;
`endif

    logic                clk_adc = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                clear_after_read = 1'b0;
    logic [NHIST*32-1:0] histosin;
    logic [7:0]          histostosend;
    logic                resethist;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready = 1'b0;
    logic                busy;
    logic                done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_bytes[0:1023];
    int         rx_cnt = 0;
    int         done_cnt = 0;
    int         rh_cnt = 0;
    int         busy_cyc = 0;
    int         done_cyc = 0;
    int         cur_mode = 0;
    logic [7:0] sel_d1 = 8'd0;
    logic [7:0] sel_d2 = 8'd0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always #5 clk_adc = ~clk_adc;

    histo_readout dut (
        .clk_adc          (clk_adc),
        .rst              (rst),
        .start            (start),
        .clear_after_read (clear_after_read),
        .histosin         (histosin),
        .histostosend     (histostosend),
        .resethist        (resethist),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .done             (done)
    );

    function automatic logic [31:0] hword(input int mode, input logic [7:0] ch, input int k);
        if (mode == 0) return {ch, 8'(k), 16'h1234};
        return 32'h0;
    endfunction

    // Histogram block model: two register stages from selector to words.
    always @(posedge clk_adc) begin
        sel_d1 <= histostosend;
        sel_d2 <= sel_d1;
    end

    always_comb begin
        histosin = '0;
        for (int k = 0; k < int'(NHIST); k++) histosin[32*k +: 32] = hword(cur_mode, sel_d2, k);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input int mode);
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.push_back(HDR);
        x = HDR;
        for (int c = 0; c < int'(NCHAN); c++)
            for (int k = 0; k < int'(NHIST); k++) begin
                w = hword(mode, 8'(c), k);
                for (int b = 3; b >= 0; b--) begin
                    exp_q.push_back(w[8*b +: 8]);
                    x = x ^ w[8*b +: 8];
                end
            end
`ifdef HISTO_READOUT_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Monitor: scoreboard pops, stall stability, done/clear bookkeeping.
    always @(negedge clk_adc) begin
        if (!rst) begin
            if (busy) busy_cyc++;
            if (prev_stall) begin
                chk("stall_valid_held", 32'(tx_valid), 32'd1);
                chk("stall_data_held", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(rx_cnt), 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("byte_%0d", rx_cnt), 32'(tx_data), 32'(exp_q.pop_front()));
                end
                if (rx_cnt < 1024) rx_bytes[rx_cnt] = tx_data;
                rx_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = busy_cyc;
            end
            if (resethist) begin
                rh_cnt++;
                chk("resethist_on_done", 32'(done), 32'd1);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_frame(input int mode, input logic clr, input int rdy_pct,
                             input logic restart, input int exp_rh);
        logic finished;
        cur_mode = mode;
        push_frame(mode);
        rx_cnt = 0; done_cnt = 0; rh_cnt = 0; busy_cyc = 0; done_cyc = 0;
        finished = 1'b0;
        @(posedge clk_adc); #1;
        start = 1'b1; clear_after_read = clr;
        tx_ready = (int'($urandom_range(99)) < rdy_pct);
        @(posedge clk_adc); #1;
        start = 1'b0; clear_after_read = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_valid", 32'(tx_valid), 32'd1);
        chk("start_header", 32'(tx_data), 32'(HDR));
        for (int i = 0; i < 20000; i++) begin
            tx_ready = (int'($urandom_range(99)) < rdy_pct);
            if (restart) start = (i == 150 || i == 400);
            @(posedge clk_adc); #1;
            if (done_cnt != 0 && busy === 1'b0) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("frame_complete", 32'(finished), 32'd1);
        repeat (6) @(posedge clk_adc);
        #1;
        chk("idle_after_frame", 32'(busy), 32'd0);
        chk("frame_len", 32'(rx_cnt), 32'(FRAME_LEN));
        chk("single_done", 32'(done_cnt), 32'd1);
        chk("resethist_count", 32'(rh_cnt), 32'(exp_rh));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        if (rdy_pct >= 100) chk("done_cycle", 32'(done_cyc), 32'(FRAME_CYC));
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk_adc);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_resethist", 32'(resethist), 32'd0);
        chk("rst_sel", 32'(histostosend), 32'd0);
        rst = 1'b0;

        // Ready tied high, counting pattern, no clear
        run_frame(0, 1'b0, 100, 1'b0, 0);
        chk("b1_ch0_msb", 32'(rx_bytes[1]), 32'h00);
        chk("b5_ch0_w1_msb", 32'(rx_bytes[5]), 32'h00);
        chk("ch15_w7_b0", 32'(rx_bytes[509]), 32'h0F);
        chk("ch15_w7_b1", 32'(rx_bytes[510]), 32'h07);
        chk("ch15_w7_b2", 32'(rx_bytes[511]), 32'h12);
        chk("ch15_w7_b3", 32'(rx_bytes[512]), 32'h34);

        // Random 30% ready, clear requested, start re-pulsed mid-frame
        run_frame(0, 1'b1, 30, 1'b1, 1);

        // Reset in the middle of channel 5
        cur_mode = 0;
        push_frame(0);
        rx_cnt = 0; done_cnt = 0; rh_cnt = 0;
        @(posedge clk_adc); #1;
        start = 1'b1; clear_after_read = 1'b1; tx_ready = 1'b1;
        @(posedge clk_adc); #1;
        start = 1'b0; clear_after_read = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (rx_cnt >= 171) break;
            @(posedge clk_adc); #1;
        end
        chk("reached_ch5", 32'(histostosend), 32'd5);
        rst = 1'b1;
        @(posedge clk_adc); #1;
        chk("midrst_valid", 32'(tx_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sel", 32'(histostosend), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (20) @(posedge clk_adc);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_no_clear", 32'(rh_cnt), 32'd0);
        chk("midrst_stays_idle", 32'(busy), 32'd0);

        // All-zero histogram words
        run_frame(1, 1'b0, 100, 1'b0, 0);
`ifdef HISTO_READOUT_CHECKSUM_EN
        chk("zero_checksum", 32'(rx_bytes[513]), 32'hA5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
